// File: rtl/main_memory_ws_pkg.sv
// Shared definitions for main_memory_ws: FSM state encodings, operation type, address-width helper.
package main_memory_ws_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUSY    = 2'd1;
    localparam logic [1:0] ST_ACK     = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    function automatic int addr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/main_memory_ws_if.sv
// RD/WR/ACK memory port bundle; ERR_Out exists only when MAIN_MEMORY_WS_RANGECHK_EN is defined.
interface main_memory_ws_if #(
    parameter int DATAWIDTH_BUS = 32
);
    logic [DATAWIDTH_BUS-1:0] A_InBus;
    logic [DATAWIDTH_BUS-1:0] B_InBus;
    logic                     RD_In;
    logic                     WR_In;
    logic                     ACK_Out;
    logic [DATAWIDTH_BUS-1:0] Data_OutBus;
`ifdef MAIN_MEMORY_WS_RANGECHK_EN
    logic                     ERR_Out;
`endif

    modport master (
        output A_InBus, B_InBus, RD_In, WR_In,
`ifdef MAIN_MEMORY_WS_RANGECHK_EN
        input  ERR_Out,
`endif
        input  ACK_Out, Data_OutBus
    );

    modport slave (
        input  A_InBus, B_InBus, RD_In, WR_In,
`ifdef MAIN_MEMORY_WS_RANGECHK_EN
        output ERR_Out,
`endif
        output ACK_Out, Data_OutBus
    );
endinterface

// File: rtl/main_memory_ws_array.sv
// Single-port synchronous RAM; dout is a register that only updates on a read strobe and clears on reset.
module main_memory_ws_array #(
    parameter int DW    = 32,
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] din_i,
    output logic [DW-1:0] dout_o
);
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] dout_q;

    // Contents are deliberately never reset.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[addr_i] <= din_i;
    end

    always_ff @(posedge clk) begin
        if (rst)       dout_q <= '0;
        else if (re_i) dout_q <= mem_q[addr_i];
    end

    assign dout_o = dout_q;
endmodule

// File: rtl/main_memory_ws.sv
// Word-addressed memory with WAIT_STATES extra cycles before ACK and a four-phase RD/WR/ACK handshake.
// Define MAIN_MEMORY_WS_RANGECHK_EN to flag (and suppress) accesses whose upper address bits are non-zero.
//
// state      | meaning
// IDLE       | waiting for RD|WR; operands latched on the accepting edge
// BUSY       | counting wait states; bus ignored
// ACK        | first cycle with ACK high
// RELEASE    | ACK held until RD and WR both drop
module main_memory_ws
    import main_memory_ws_pkg::*;
#(
    parameter int DATAWIDTH_BUS = 32,
    parameter int DEPTH         = 256,
    parameter int WAIT_STATES   = 2
) (
    input  logic             MAIN_MEMORY_WS_CLOCK_50,
    input  logic             MAIN_MEMORY_WS_ResetInHigh_In,
    main_memory_ws_if.slave  bus
);
    localparam int AW = addr_width(DEPTH);

    logic                     clk;
    logic                     rst;
    logic                     req;
    logic                     fire;
    logic                     blocked;
    logic                     ram_we;
    logic                     ram_re;
    logic [DATAWIDTH_BUS-1:0] rdata;

    logic [1:0]               state_q, state_d;
    logic [3:0]               cnt_q, cnt_d;
    logic [AW-1:0]            addr_q, addr_d;
    logic [DATAWIDTH_BUS-1:0] wdata_q, wdata_d;
    op_e                      op_q, op_d;
    logic                     ack_q, ack_d;
`ifdef MAIN_MEMORY_WS_RANGECHK_EN
    logic                     oor_q, oor_d;
    logic                     err_q, err_d;
`endif

    assign clk = MAIN_MEMORY_WS_CLOCK_50;
    assign rst = MAIN_MEMORY_WS_ResetInHigh_In;
    assign req = bus.RD_In | bus.WR_In;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        op_d    = op_q;
        ack_d   = ack_q;
        fire    = 1'b0;
`ifdef MAIN_MEMORY_WS_RANGECHK_EN
        oor_d   = oor_q;
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    addr_d  = bus.A_InBus[AW-1:0];
                    wdata_d = bus.B_InBus;
                    op_d    = bus.WR_In ? OP_WRITE : OP_READ;
                    cnt_d   = 4'(WAIT_STATES);
`ifdef MAIN_MEMORY_WS_RANGECHK_EN
                    oor_d   = (bus.A_InBus >> AW) != '0;
`endif
                    state_d = ST_BUSY;
                end
            end
            // cnt starts at WAIT_STATES so that ACK lands WAIT_STATES+1 edges after capture.
            ST_BUSY: begin
                if (cnt_q == 4'd0) begin
                    fire    = 1'b1;
                    ack_d   = 1'b1;
                    state_d = ST_ACK;
`ifdef MAIN_MEMORY_WS_RANGECHK_EN
                    err_d   = oor_q;
`endif
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ACK, ST_RELEASE: begin
                if (!req) begin
                    ack_d   = 1'b0;
                    state_d = ST_IDLE;
`ifdef MAIN_MEMORY_WS_RANGECHK_EN
                    err_d   = 1'b0;
`endif
                end else begin
                    state_d = ST_RELEASE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef MAIN_MEMORY_WS_RANGECHK_EN
    assign blocked     = oor_q;
    assign bus.ERR_Out = err_q;
`else
    assign blocked     = 1'b0;
`endif

    // Gated with rst so an access completing on a reset edge never touches the array.
    assign ram_we = fire && !blocked && !rst && (op_q == OP_WRITE);
    assign ram_re = fire && !blocked && !rst && (op_q == OP_READ);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            op_q    <= OP_READ;
            ack_q   <= 1'b0;
`ifdef MAIN_MEMORY_WS_RANGECHK_EN
            oor_q   <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            op_q    <= op_d;
            ack_q   <= ack_d;
`ifdef MAIN_MEMORY_WS_RANGECHK_EN
            oor_q   <= oor_d;
            err_q   <= err_d;
`endif
        end
    end

    main_memory_ws_array #(
        .DW    (DATAWIDTH_BUS),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk    (clk),
        .rst    (rst),
        .we_i   (ram_we),
        .re_i   (ram_re),
        .addr_i (addr_q),
        .din_i  (wdata_q),
        .dout_o (rdata)
    );

    assign bus.ACK_Out     = ack_q;
    assign bus.Data_OutBus = rdata;
endmodule

// File: tb/tb_main_memory_ws.sv
// Directed + randomized bench for main_memory_ws (WAIT_STATES=2 and a WAIT_STATES=0 instance).
// Honours MAIN_MEMORY_WS_RANGECHK_EN when defined.
module tb_main_memory_ws;
    localparam int WS    = 2;
    localparam int DEPTH = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    main_memory_ws_if #(.DATAWIDTH_BUS(32)) bus  ();
    main_memory_ws_if #(.DATAWIDTH_BUS(32)) bus0 ();

    main_memory_ws #(.DATAWIDTH_BUS(32), .DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
        .MAIN_MEMORY_WS_CLOCK_50       (clk),
        .MAIN_MEMORY_WS_ResetInHigh_In (rst),
        .bus                           (bus)
    );

    main_memory_ws #(.DATAWIDTH_BUS(32), .DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
        .MAIN_MEMORY_WS_CLOCK_50       (clk),
        .MAIN_MEMORY_WS_ResetInHigh_In (rst),
        .bus                           (bus0)
    );

    // Reference model: word array, which words hold known data, expected read register.
    logic [31:0] mem_m   [DEPTH];
    bit          valid_m [DEPTH];
    logic [31:0] dout_m;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One complete handshake on the WAIT_STATES=2 instance; mangle changes A/B right after capture.
    task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] b, input bit mangle);
        int  cyc;
        int  idx;
        bit  in_rng;
        @(negedge clk);
        bus.RD_In = rd; bus.WR_In = wr; bus.A_InBus = a; bus.B_InBus = b;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (mangle && cyc == 1) begin
                bus.A_InBus = a + 32'd1;
                bus.B_InBus = 32'h55;
            end
        end while (!bus.ACK_Out && cyc < 50);
        check("ack_latency", 32'(cyc), 32'(WS + 2));

        idx    = int'(a % DEPTH);
`ifdef MAIN_MEMORY_WS_RANGECHK_EN
        in_rng = (a / DEPTH) == 0;
        check("err_with_ack", {31'd0, bus.ERR_Out}, {31'd0, !in_rng});
`else
        in_rng = 1'b1;
`endif
        if (in_rng) begin
            if (wr) begin
                mem_m[idx]   = b;
                valid_m[idx] = 1'b1;
            end else begin
                dout_m = mem_m[idx];
            end
        end
        check(wr ? "data_after_write" : "data_after_read", bus.Data_OutBus, dout_m);

        bus.RD_In = 1'b0; bus.WR_In = 1'b0;
        @(negedge clk);
        check("ack_fall", {31'd0, bus.ACK_Out}, 32'd0);
`ifdef MAIN_MEMORY_WS_RANGECHK_EN
        check("err_fall", {31'd0, bus.ERR_Out}, 32'd0);
`endif
    endtask

    initial begin
        int          cyc;
        int          r;
        logic [31:0] a;
        logic [31:0] b;

        bus.RD_In = 0;  bus.WR_In = 0;  bus.A_InBus = 0;  bus.B_InBus = 0;
        bus0.RD_In = 0; bus0.WR_In = 0; bus0.A_InBus = 0; bus0.B_InBus = 0;
        dout_m = 32'd0;
        for (int i = 0; i < DEPTH; i++) valid_m[i] = 1'b0;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_ack", {31'd0, bus.ACK_Out}, 32'd0);
        check("reset_data", bus.Data_OutBus, 32'd0);
        check("reset_ack_ws0", {31'd0, bus0.ACK_Out}, 32'd0);
        rst = 1'b0;

        // Write then read back.
        access(1'b0, 1'b1, 32'h05, 32'hDEADBEEF, 1'b0);
        access(1'b1, 1'b0, 32'h05, 32'h0, 1'b0);
        check("read_0x05", bus.Data_OutBus, 32'hDEADBEEF);

        // Simultaneous RD/WR behaves as a write.
        access(1'b1, 1'b1, 32'h10, 32'h12345678, 1'b0);
        check("rdwr_keeps_data", bus.Data_OutBus, 32'hDEADBEEF);
        access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
        check("read_0x10", bus.Data_OutBus, 32'h12345678);

        // Operands are latched at capture.
        access(1'b0, 1'b1, 32'h21, 32'h21212121, 1'b0);
        access(1'b0, 1'b1, 32'h20, 32'hAAAA0000, 1'b1);
        access(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
        check("stable_0x20", bus.Data_OutBus, 32'hAAAA0000);
        access(1'b1, 1'b0, 32'h21, 32'h0, 1'b0);
        check("stable_0x21", bus.Data_OutBus, 32'h21212121);

        // Reset during BUSY discards the pending write.
        access(1'b0, 1'b1, 32'h30, 32'h30303030, 1'b0);
        @(negedge clk);
        bus.WR_In = 1'b1; bus.A_InBus = 32'h30; bus.B_InBus = 32'h1;
        @(negedge clk);
        rst = 1'b1; bus.WR_In = 1'b0;
        @(negedge clk);
        check("midreset_ack", {31'd0, bus.ACK_Out}, 32'd0);
        rst = 1'b0;
        dout_m = 32'd0;
        @(negedge clk);
        check("midreset_ack_after", {31'd0, bus.ACK_Out}, 32'd0);
        access(1'b1, 1'b0, 32'h30, 32'h0, 1'b0);
        check("midreset_array", bus.Data_OutBus, 32'h30303030);

        // Upper address bits: alias (default) or flagged error (range check).
        access(1'b0, 1'b1, 32'h00, 32'h0000C0DE, 1'b0);
        access(1'b0, 1'b1, 32'h100, 32'hA11A5000, 1'b0);
        access(1'b1, 1'b0, 32'h00, 32'h0, 1'b0);

        // WAIT_STATES=0 instance: ACK one edge after capture.
        @(negedge clk);
        bus0.WR_In = 1'b1; bus0.A_InBus = 32'h07; bus0.B_InBus = 32'hCAFEF00D;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!bus0.ACK_Out && cyc < 50);
        check("ws0_write_latency", 32'(cyc), 32'd2);
        bus0.WR_In = 1'b0;
        @(negedge clk);
        check("ws0_ack_fall", {31'd0, bus0.ACK_Out}, 32'd0);
        bus0.RD_In = 1'b1;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!bus0.ACK_Out && cyc < 50);
        check("ws0_read_latency", 32'(cyc), 32'd2);
        check("ws0_read_data", bus0.Data_OutBus, 32'hCAFEF00D);
        bus0.RD_In = 1'b0;
        @(negedge clk);

        // Randomized traffic against the model.
        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 3));
            a = 32'($urandom_range(0, DEPTH - 1));
            b = $urandom;
            if (r == 3) a = a | ($urandom & 32'hFFFF_FF00) | 32'h100;
            if (r == 0 && !valid_m[int'(a % DEPTH)]) r = 1;
            case (r)
                0:       access(1'b1, 1'b0, a, b, 1'b0);
                2:       access(1'b1, 1'b1, a, b, 1'b0);
                default: access(1'b0, 1'b1, a, b, 1'b0);
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
